galois_pow3: RTL and testbench
==============================

# galois_pow3

Fixed-latency modular cube unit: computes result = base³ mod MODULUS over the BN254 scalar field. It is the nonlinear round function of the MiMC hash core. It is built from one sequential shift-and-add ("peasant") modular multiplier that is used twice: first for base·base, then for the square times base.

## Interface
Parameters:
- N_BITS, default 254: operand/result width.
- GALOIS_MULT_METHOD, default "peasant": multiplier architecture. Only "peasant" is legal; any other value is an elaboration error.
- MODULUS, default 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001: field prime p, required MODULUS < 2^N_BITS < 2·MODULUS.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: one clock; reset is synchronous and active-high.
- en, input, 1: start/hold request, level-sensitive.
- base, input, N_BITS: operand, sampled at start.
- result, output, N_BITS: base³ mod p, valid while done=1.
- done, output, 1: completion flag.

## Operation
- States: IDLE, MUL1, MUL2, DONE.
- IDLE with en=1 (start edge):
  - Latch x = base, or base−MODULUS if base ≥ MODULUS.
  - acc=0, bit counter=N_BITS−1, go to MUL1.
- MUL1 (N_BITS cycles), MSB-first over multiplier x, multiplicand x:
  - acc ← (2·acc mod p) + (x[bit] ? x : 0), then mod p.
  - Each mod p is a single conditional subtraction.
  - After bit 0: sq=acc, acc=0, counter=N_BITS−1, go to MUL2.
- MUL2 (N_BITS cycles): same recurrence, multiplier sq, multiplicand x.
  - After bit 0: result ← acc, done ← 1, go to DONE.
- DONE: hold result and done=1 while en=1. When en=0: done ← 0, go to IDLE; result keeps its last value.
- en=0 during MUL1/MUL2: abort to IDLE; done stays 0, result unchanged.
- Intermediate values always stay < p. Internal adders are N_BITS+1 bits wide.

## Timing
- rst=1 at a clock edge:
  - state=IDLE, result=0, done=0, internal registers cleared.
  - Applies in any state, including mid-operation; overrides en.
- Latency: done rises exactly 2·N_BITS edges after the start edge (508 cycles for N_BITS=254).
- done and result are registered outputs; result is stable whenever done=1.
- base is sampled only at the start edge; later changes are ignored.
- en held high after DONE does not restart the unit. A new operation needs en low for ≥1 cycle, then high again.
- Start edge coinciding with rst=1: reset wins, no start.

## Configuration
- GALOIS_POW3_ASSERT_EN defined:
  - Simulation assertions are compiled in.
  - Checks: result < MODULUS whenever done=1; done never rises earlier than 2·N_BITS cycles after start; GALOIS_MULT_METHOD=="peasant".
  - Any failure issues $error.
- Undefined: no assertion logic. Functional behaviour is identical in both builds.

## Test plan
- Reset: rst=1 for 2 cycles with en=1 → result=0, done=0, state IDLE.
- base=2, en=1 → done after 508 cycles, result=8; base=3 → result=27.
- Boundary values:
  - base=0 → 0; base=1 → 1.
  - base=p−1 → p−1 (…f0000000).
  - base=p+1 → 1 (input reduction).
- Random 254-bit base < p vs. golden model pow(base,3,p) → exact match; done high, result stable while en stays 1.
- Mid-operation: rst=1 at cycle 300 → done=0, result=0. Rerun from IDLE with base=5 → 125.
- Abort/restart: drop en at cycle 100 → no done, result unchanged. en low 1 cycle, then high with base=7 → 343 after 508 cycles.

Source files
------------

// File: rtl/galois_pow3.sv
// galois_pow3: base^3 mod MODULUS via one shift-and-add modular multiplier used twice.
// Define GALOIS_POW3_ASSERT_EN to compile in simulation assertions.
module galois_pow3 #(
    parameter int N_BITS = 254,
    parameter GALOIS_MULT_METHOD = "peasant",
    parameter logic [N_BITS-1:0] MODULUS =
        254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_BITS-1:0] base,
    output logic [N_BITS-1:0] result,
    output logic              done
);

    localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(N_BITS - 1);
    localparam logic [N_BITS:0] P = {1'b0, MODULUS};

    generate
        if (GALOIS_MULT_METHOD != "peasant") begin : g_bad_method
            $error("galois_pow3: only the peasant multiplier is supported");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        MUL1,
        MUL2,
        DONE
    } state_t;

    state_t            state, state_n;
    logic [N_BITS-1:0] x, x_n;
    logic [N_BITS-1:0] sq, sq_n;
    logic [N_BITS-1:0] acc, acc_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [N_BITS-1:0] result_n;
    logic              done_n;

    logic [N_BITS-1:0] base_r;
    logic [N_BITS-1:0] mult;
    logic              mbit;
    logic [N_BITS:0]   dbl;
    logic [N_BITS-1:0] dbl_m;
    logic [N_BITS:0]   sum;
    logic [N_BITS-1:0] step;

    // Since 2^N_BITS < 2p, one subtraction fully reduces any raw operand.
    assign base_r = (base >= MODULUS) ? base - MODULUS : base;

    // One multiplier step: acc*2 + (bit ? x : 0), each term kept below p.
    always_comb begin
        mult  = (state == MUL2) ? sq : x;
        mbit  = mult[cnt];
        dbl   = {acc, 1'b0};
        dbl_m = (dbl >= P) ? N_BITS'(dbl - P) : dbl[N_BITS-1:0];
        sum   = {1'b0, dbl_m} + {1'b0, (mbit ? x : '0)};
        step  = (sum >= P) ? N_BITS'(sum - P) : sum[N_BITS-1:0];
    end

    always_comb begin
        state_n  = state;
        x_n      = x;
        sq_n     = sq;
        acc_n    = acc;
        cnt_n    = cnt;
        result_n = result;
        done_n   = done;
        unique case (state)
            IDLE: begin
                if (en) begin
                    x_n     = base_r;
                    acc_n   = '0;
                    cnt_n   = CNT_TOP;
                    state_n = MUL1;
                end
            end
            MUL1: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (cnt == '0) begin
                    sq_n    = step;
                    acc_n   = '0;
                    cnt_n   = CNT_TOP;
                    state_n = MUL2;
                end else begin
                    acc_n = step;
                    cnt_n = cnt - CW'(1);
                end
            end
            MUL2: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (cnt == '0) begin
                    acc_n    = step;
                    result_n = step;
                    done_n   = 1'b1;
                    state_n  = DONE;
                end else begin
                    acc_n = step;
                    cnt_n = cnt - CW'(1);
                end
            end
            DONE: begin
                if (!en) begin
                    done_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            x      <= '0;
            sq     <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            x      <= x_n;
            sq     <= sq_n;
            acc    <= acc_n;
            cnt    <= cnt_n;
            result <= result_n;
            done   <= done_n;
        end
    end

`ifdef GALOIS_POW3_ASSERT_EN
    int unsigned run_cyc;

    always_ff @(posedge clk) begin
        if (rst || state == IDLE)
            run_cyc <= 0;
        else
            run_cyc <= run_cyc + 1;
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (GALOIS_MULT_METHOD == "peasant")
            else $error("galois_pow3: illegal multiplier method");
            assert (!done || result < MODULUS)
            else $error("galois_pow3: result not reduced");
            if (done_n && !done)
                assert (run_cyc + 1 >= 2 * N_BITS)
                else $error("galois_pow3: done raised early");
        end
    end
`endif

endmodule

// File: tb/tb_galois_pow3.sv
// tb_galois_pow3: directed vector table plus reset/abort sequences
// and a few random operands against a wide-arithmetic cube model.
module tb_galois_pow3;

    localparam int N   = 254;
    localparam int LAT = 2 * N;
    localparam logic [N-1:0] P =
        254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
    localparam logic [511:0] P512 = {258'b0, P};

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [N-1:0] base;
    logic [N-1:0] result;
    logic         done;

    int total = 0;
    int bad   = 0;

    galois_pow3 dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .base(base),
        .result(result),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] b;
        logic [N-1:0] r;
        string        name;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name,
                         input logic [N-1:0] got,
                         input logic [N-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [N-1:0] cube(input logic [N-1:0] b);
        logic [511:0] t;
        t = ({258'b0, b} * {258'b0, b}) % P512;
        t = (t * {258'b0, b}) % P512;
        return t[N-1:0];
    endfunction

    task automatic run_op(input logic [N-1:0] b,
                          input logic [N-1:0] exp,
                          input string name);
        int cyc;
        @(negedge clk);
        base = b;
        en   = 1'b1;
        @(posedge clk);
        #1;
        check({name, " busy"}, done, 0);
        cyc = 0;
        @(negedge clk);
        base = ~b;
        while (!done && cyc < LAT + 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({name, " latency"}, cyc, LAT);
        check({name, " result"}, result, exp);
        repeat (3) @(posedge clk);
        #1;
        check({name, " hold done"}, done, 1);
        check({name, " hold result"}, result, exp);
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        check({name, " done fall"}, done, 0);
        check({name, " keep result"}, result, exp);
    endtask

    initial begin
        logic [255:0] r256;
        logic [N-1:0] rb;
        bit           seen;

        vecs[0] = '{254'd2, 254'd8, "base2"};
        vecs[1] = '{254'd3, 254'd27, "base3"};
        vecs[2] = '{254'd0, 254'd0, "base0"};
        vecs[3] = '{254'd1, 254'd1, "base1"};
        vecs[4] = '{P - 254'd1, P - 254'd1, "p_minus_1"};
        vecs[5] = '{P + 254'd1, 254'd1, "p_plus_1"};

        rst  = 1'b1;
        en   = 1'b1;
        base = 254'd2;
        repeat (2) @(posedge clk);
        #1;
        check("reset result", result, 0);
        check("reset done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        @(posedge clk);

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].b, vecs[i].r, vecs[i].name);

        @(negedge clk);
        base = 254'd9;
        en   = 1'b1;
        repeat (300) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst done", done, 0);
        check("midrst result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        @(posedge clk);
        run_op(254'd5, 254'd125, "rerun5");

        @(negedge clk);
        base = 254'd11;
        en   = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        en   = 1'b0;
        seen = 1'b0;
        repeat (LAT) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("abort no done", seen, 0);
        check("abort result", result, 254'd125);
        run_op(254'd7, 254'd343, "restart7");

        for (int i = 0; i < 3; i++) begin
            for (int w = 0; w < 8; w++)
                r256[w*32 +: 32] = $urandom;
            r256 = r256 % {2'b0, P};
            rb   = r256[N-1:0];
            run_op(rb, cube(rb), $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
